// File: rtl/ascon_ctrl_pkg.sv
// ascon_ctrl_pkg: FSM state enum, dp_op codes and round-index constants for the Ascon-128 AEAD sequencer
package ascon_ctrl_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_INIT_LOAD, S_INIT_PERM, S_INIT_KEY, S_AD_WAIT, S_AD_PERM, S_DSEP,
      S_PT_WAIT, S_PT_OUT, S_PT_PERM, S_FIN_KEY, S_FIN_PERM, S_FIN_TAG, S_TAG_OUT
   } state_t;
   localparam logic [3:0] OP_NOP     = 4'd0;
   localparam logic [3:0] OP_LOAD_IV = 4'd1;
   localparam logic [3:0] OP_XOR_KEY = 4'd2;
   localparam logic [3:0] OP_ABSORB  = 4'd3;
   localparam logic [3:0] OP_DSEP    = 4'd4;
   localparam logic [3:0] OP_ENC     = 4'd5;
   localparam logic [3:0] OP_FIN_KEY = 4'd6;
   localparam logic [3:0] OP_TAG     = 4'd7;
   localparam logic [3:0] OP_DEC     = 4'd8;
   localparam logic [3:0] RND_IDX_PA0 = 4'd0;
   localparam logic [3:0] RND_IDX_PB0 = 4'd6;
   function automatic logic is_perm(state_t s);
      return s inside {S_INIT_PERM, S_AD_PERM, S_PT_PERM, S_FIN_PERM};
   endfunction
endpackage

// File: rtl/ascon_rnd_cnt.sv
// ascon_rnd_cnt: loadable permutation round counter
// Ports: clk/rst_n (async active-low); load with ld_idx (first round index) and ld_len (round count);
//        en advances one round; idx is the current round index; last_rnd flags the final round.
module ascon_rnd_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       en,
   input  logic [3:0] ld_idx,
   input  logic [3:0] ld_len,
   output logic [3:0] idx,
   output logic       last_rnd
);
   logic [3:0] rem;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         idx <= '0;
         rem <= '0;
      end else if (load) begin
         idx <= ld_idx;
         rem <= ld_len - 4'd1;
      end else if (en) begin
         idx <= idx + 4'd1;
         rem <= rem - 4'd1;
      end
   assign last_rnd = rem == 4'd0;
endmodule

// File: rtl/ascon_aead_seq.sv
// ascon_aead_seq: control sequencer driving a one-round-per-cycle Ascon-128 AEAD permutation datapath
// Ports: CLK, RST_N (async active-low); start with n_ad/n_pt block counts (latched);
//        in_valid/in_ready AD/PT block stream; out_valid/out_ready/out_is_tag ciphertext/tag stream;
//        dp_op/dp_we datapath op strobe; rnd_en/rnd_idx round control; busy, done status.
// Optional: ASCON_DECRYPT_EN adds input dec (latched on start) selecting DEC instead of ENC.
module ascon_aead_seq
   import ascon_ctrl_pkg::*;
#(
   parameter int A_ROUNDS = 12,
   parameter int B_ROUNDS = 6,
   parameter int CNT_W    = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
`ifdef ASCON_DECRYPT_EN
   input  logic             dec,
`endif
   input  logic             start,
   input  logic [CNT_W-1:0] n_ad,
   input  logic [CNT_W-1:0] n_pt,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_is_tag,
   output logic [3:0]       dp_op,
   output logic             dp_we,
   output logic             rnd_en,
   output logic [3:0]       rnd_idx,
   output logic             busy,
   output logic             done
);
   state_t state, state_n;
   logic [CNT_W-1:0] ad_cnt, pt_cnt;
   logic [3:0] op_s, idx;
   logic last_rnd, rc_load, rc_pb, dec_q;
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state  <= S_IDLE;
         ad_cnt <= '0;
         pt_cnt <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_n;
         done  <= state == S_TAG_OUT && out_ready;
         if (state == S_IDLE && start) begin
            ad_cnt <= n_ad;
            pt_cnt <= n_pt == '0 ? CNT_W'(1) : n_pt;
         end
         if (state == S_AD_WAIT && in_valid) ad_cnt <= ad_cnt - CNT_W'(1);
         if (state == S_PT_OUT && out_ready) pt_cnt <= pt_cnt - CNT_W'(1);
      end
`ifdef ASCON_DECRYPT_EN
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) dec_q <= 1'b0;
      else if (state == S_IDLE && start) dec_q <= dec;
`else
   assign dec_q = 1'b0;
`endif
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:      state_n = start ? S_INIT_LOAD : S_IDLE;
         S_INIT_LOAD: state_n = S_INIT_PERM;
         S_INIT_PERM: state_n = last_rnd ? S_INIT_KEY : S_INIT_PERM;
         S_INIT_KEY:  state_n = ad_cnt == '0 ? S_DSEP : S_AD_WAIT;
         S_AD_WAIT:   state_n = in_valid ? S_AD_PERM : S_AD_WAIT;
         S_AD_PERM:   state_n = !last_rnd ? S_AD_PERM : ad_cnt != '0 ? S_AD_WAIT : S_DSEP;
         S_DSEP:      state_n = S_PT_WAIT;
         S_PT_WAIT:   state_n = in_valid ? S_PT_OUT : S_PT_WAIT;
         // the final PT block skips p^b and goes straight to finalization
         S_PT_OUT:    state_n = !out_ready ? S_PT_OUT : pt_cnt == CNT_W'(1) ? S_FIN_KEY : S_PT_PERM;
         S_PT_PERM:   state_n = last_rnd ? S_PT_WAIT : S_PT_PERM;
         S_FIN_KEY:   state_n = S_FIN_PERM;
         S_FIN_PERM:  state_n = last_rnd ? S_FIN_TAG : S_FIN_PERM;
         S_FIN_TAG:   state_n = S_TAG_OUT;
         S_TAG_OUT:   state_n = out_ready ? S_IDLE : S_TAG_OUT;
         default:     state_n = S_IDLE;
      endcase
   end
   // load the round counter in the cycle that enters a permutation burst
   assign rc_load = is_perm(state_n) && !rnd_en;
   assign rc_pb   = state_n inside {S_AD_PERM, S_PT_PERM};
   ascon_rnd_cnt u_rnd (
      .clk      (CLK),
      .rst_n    (RST_N),
      .load     (rc_load),
      .en       (rnd_en),
      .ld_idx   (rc_pb ? 4'(12 - B_ROUNDS) : 4'(12 - A_ROUNDS)),
      .ld_len   (rc_pb ? 4'(B_ROUNDS) : 4'(A_ROUNDS)),
      .idx      (idx),
      .last_rnd (last_rnd)
   );
   assign op_s = state == S_INIT_LOAD ? OP_LOAD_IV :
                 state == S_INIT_KEY  ? OP_XOR_KEY :
                 state == S_AD_WAIT   ? OP_ABSORB  :
                 state == S_DSEP      ? OP_DSEP    :
                 state == S_PT_WAIT   ? (dec_q ? OP_DEC : OP_ENC) :
                 state == S_FIN_KEY   ? OP_FIN_KEY :
                 state == S_FIN_TAG   ? OP_TAG     : OP_NOP;
   assign in_ready   = state inside {S_AD_WAIT, S_PT_WAIT};
   assign out_valid  = state inside {S_PT_OUT, S_TAG_OUT};
   assign out_is_tag = state == S_TAG_OUT;
   // wait-state ops apply only on the input handshake
   assign dp_we      = in_ready ? in_valid : op_s != OP_NOP;
   assign dp_op      = dp_we ? op_s : OP_NOP;
   assign rnd_en     = is_perm(state);
   assign rnd_idx    = rnd_en ? idx : 4'd0;
   assign busy       = state != S_IDLE;
endmodule

// File: tb/tb_ascon_aead_seq.sv
// tb_ascon_aead_seq: self-checking bench for ascon_aead_seq against a phase-level reference model
module tb_ascon_aead_seq;
   logic CLK = 1'b0, RST_N = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0] n_ad = '0, n_pt = '0;
   logic in_ready, out_valid, out_is_tag, dp_we, rnd_en, busy, done;
   logic [3:0] dp_op, rnd_idx;
`ifdef ASCON_DECRYPT_EN
   logic dec = 1'b0;
`endif
   int tests = 0, fails = 0;

   ascon_aead_seq dut (
      .CLK(CLK), .RST_N(RST_N),
`ifdef ASCON_DECRYPT_EN
      .dec(dec),
`endif
      .start(start), .n_ad(n_ad), .n_pt(n_pt),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_is_tag(out_is_tag), .dp_op(dp_op), .dp_we(dp_we), .rnd_en(rnd_en), .rnd_idx(rnd_idx),
      .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int all_out();
      return int'({in_ready, out_valid, out_is_tag, dp_op, dp_we, rnd_en, rnd_idx, busy, done});
   endfunction

   // mode: 0 clean, 1 random stalls, 2 directed backpressure, 3 start re-pulsed at cycle 10, 4 reset in FIN_PERM
   task automatic run_op(input int na, input int np, input bit d, input int mode);
      int exp_op[$], exp_idx[$], got_op[$], got_idx[$];
      int enp, cyc, lat, dones, hold_i, hold_o, n_fin;
      bit fin;
      enp = np == 0 ? 1 : np;
      exp_op = '{1, 2};
      for (int i = 0; i < na; i++) exp_op.push_back(3);
      exp_op.push_back(4);
      for (int i = 0; i < enp; i++) exp_op.push_back(d ? 8 : 5);
      exp_op.push_back(6);
      exp_op.push_back(7);
      for (int i = 0; i < 12; i++) exp_idx.push_back(i);
      for (int b = 0; b < na + enp - 1; b++)
         for (int i = 6; i < 12; i++) exp_idx.push_back(i);
      for (int i = 0; i < 12; i++) exp_idx.push_back(i);
      @(negedge CLK);
      n_ad = 4'(na); n_pt = 4'(np); start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
`ifdef ASCON_DECRYPT_EN
      dec = d;
`endif
      cyc = 0; lat = -1; dones = 0; hold_i = 0; hold_o = 0; fin = 1'b0; n_fin = 0;
      while (!fin && cyc < 3000) begin
         @(negedge CLK);
         cyc++;
         start = mode == 3 && cyc == 10;
         n_ad = 4'($urandom); n_pt = 4'($urandom);
`ifdef ASCON_DECRYPT_EN
         dec = 1'($urandom);
`endif
         in_valid = mode == 1 ? $urandom_range(0, 2) != 0 : 1'b1;
         out_ready = mode == 1 ? $urandom_range(0, 2) != 0 : 1'b1;
         if (mode == 2 && in_ready && hold_i < 3) begin in_valid = 1'b0; hold_i++; end
         if (mode == 2 && out_valid && !out_is_tag && hold_o < 5) begin out_ready = 1'b0; hold_o++; end
         #1;
         if (dp_we) got_op.push_back(int'(dp_op));
         if (rnd_en) got_idx.push_back(int'(rnd_idx));
         if (dp_we && dp_op == 4'd6) n_fin++;
         check("invariants", int'({in_ready & out_valid, rnd_en & dp_we, !rnd_en && rnd_idx != 0,
                                   out_is_tag & !out_valid}), 0);
         if (mode == 2 && hold_o > 0 && hold_o < 5)
            check("backpressure_hold", int'({out_valid, out_is_tag, in_ready, rnd_en}), 4'b1000);
         if (out_valid && out_is_tag && out_ready) lat = cyc;
         if (mode == 4 && n_fin > 0 && rnd_en && rnd_idx == 4'd4) begin
            RST_N = 1'b0;
            #1;
            check("abort_outputs_zero", all_out(), 0);
            start = 1'b0;
            return;
         end
         if (done) begin
            dones++;
            fin = 1'b1;
            check("busy_at_done", int'(busy), 0);
         end else check("busy_during_op", int'(busy), 1);
      end
      start = 1'b0;
      check("op_completed", int'(fin), 1);
      repeat (3) begin
         @(negedge CLK);
         #1;
         if (done) dones++;
      end
      check("done_once", dones, 1);
      if (mode != 1) check("tag_latency", lat, 14 + 7 * na + 1 + 2 * enp + 6 * (enp - 1) + 15 + (mode == 2 ? 8 : 0));
      check("op_count", got_op.size(), exp_op.size());
      for (int i = 0; i < got_op.size() && i < exp_op.size(); i++)
         check($sformatf("op[%0d]", i), got_op[i], exp_op[i]);
      check("rnd_count", got_idx.size(), exp_idx.size());
      for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++)
         check($sformatf("rnd_idx[%0d]", i), got_idx[i], exp_idx[i]);
   endtask

   initial begin
      #1;
      check("reset_outputs", all_out(), 0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      #1;
      check("idle_after_reset", all_out(), 0);
      run_op(1, 1, 1'b0, 0);
      run_op(0, 3, 1'b0, 0);
      run_op(1, 1, 1'b0, 2);
      run_op(1, 2, 1'b0, 3);
      run_op(2, 0, 1'b0, 0);
      run_op(1, 1, 1'b0, 4);
      @(negedge CLK);
      check("held_in_reset", all_out(), 0);
      RST_N = 1'b1;
      @(negedge CLK);
      #1;
      check("idle_after_abort", all_out(), 0);
      run_op(1, 1, 1'b0, 0);
      for (int k = 0; k < 6; k++) run_op($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1);
`ifdef ASCON_DECRYPT_EN
      run_op(1, 2, 1'b1, 0);
      run_op(0, 1, 1'b0, 0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
